// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/writeback sequencer driving the register file and ALU
// Optional retired-instruction counter enabled by SEQ_PERF_CNT_EN.
module cpu_sequencer #(
  parameter int               PC_W     = 8,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  input  logic            zero_flag,
  output logic [4:0]      read_reg1,
  output logic [4:0]      read_reg2,
  output logic [4:0]      write_reg,
  output logic [3:0]      ALU_Sel,
  output logic [4:0]      Shamt,
  output logic            write_enable,
  output logic            busy,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0]     instr_count,
`endif
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_BZ   = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            armed_q;
  logic            load_ir;

  // Instruction register kept as its decoded fields; bit 4 carries nothing.
  logic [3:0] op_q;
  logic [4:0] rd_q, rs1_q, rs2_q;
  logic [7:0] imm_q;
  logic [3:0] alu_q;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;

  assign pc_inc = pc_q + PC_W'(1);
  assign target = PC_W'(imm_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      armed_q <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      // Blocks a start that coincides with the first edge after reset release.
      armed_q <= 1'b1;
      if (load_ir) begin
        op_q  <= imem_rdata[31:28];
        rd_q  <= imem_rdata[27:23];
        rs1_q <= imem_rdata[22:18];
        rs2_q <= imem_rdata[17:13];
        imm_q <= imem_rdata[12:5];
        alu_q <= imem_rdata[3:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    load_ir      = 1'b0;
    imem_req     = 1'b0;
    write_enable = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && armed_q) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
        end
      end
      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (imem_ack) begin
          load_ir = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        busy    = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        busy    = 1'b1;
        state_d = S_FETCH;
        case (op_q)
          OP_ALU: begin
            write_enable = 1'b1;
            pc_d         = pc_inc;
          end
          OP_BZ:   pc_d    = zero_flag ? target : pc_inc;
          OP_JMP:  pc_d    = target;
          OP_HALT: state_d = S_HALT;
          default: pc_d    = pc_inc;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
        if (start && armed_q) begin
          state_d = S_FETCH;
          pc_d    = RESET_PC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign read_reg1 = rs1_q;
  assign read_reg2 = rs2_q;
  assign write_reg = rd_q;
  assign ALU_Sel   = alu_q;
  // Branch and jump reuse the shamt bits as target, so shamt is masked for them.
  assign Shamt     = (op_q == OP_BZ || op_q == OP_JMP) ? 5'd0 : imm_q[7:3];

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (state_q == S_WB) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized self-checking bench for cpu_sequencer against an ISA-level model
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        zero_flag;
  logic [4:0]  read_reg1, read_reg2, write_reg, Shamt;
  logic [3:0]  ALU_Sel;
  logic        write_enable, busy, halted;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instr_count;
`endif

  cpu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .zero_flag    (zero_flag),
    .read_reg1    (read_reg1),
    .read_reg2    (read_reg2),
    .write_reg    (write_reg),
    .ALU_Sel      (ALU_Sel),
    .Shamt        (Shamt),
    .write_enable (write_enable),
    .busy         (busy),
`ifdef SEQ_PERF_CNT_EN
    .instr_count  (instr_count),
`endif
    .halted       (halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_pc = 0;
  int model_retired = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2,
                                      input int imm8, input int alu);
    logic [31:0] w;
    w = 32'(op & 15) << 28 | 32'(rd & 31) << 23 | 32'(rs1 & 31) << 18 | 32'(rs2 & 31) << 13
      | 32'(imm8 & 255) << 5 | 32'(alu & 15);
    return w;
  endfunction

  task automatic check_fields(input string ph, input logic [31:0] w);
    int op;
    op = int'(w >> 28);
    check({ph, "_rs1"}, 32'(read_reg1), (w >> 18) & 31);
    check({ph, "_rs2"}, 32'(read_reg2), (w >> 13) & 31);
    check({ph, "_rd"}, 32'(write_reg), (w >> 23) & 31);
    check({ph, "_alu"}, 32'(ALU_Sel), w & 15);
    check({ph, "_shamt"}, 32'(Shamt), (op == 2 || op == 3) ? 0 : (w >> 8) & 31);
  endtask

  // Entered at a negedge during the first FETCH cycle of the instruction at model_pc.
  task automatic run_instr(input logic [31:0] w, input int delay, input bit z);
    int op, tgt;
    op  = int'(w >> 28);
    tgt = int'((w >> 5) & 255);
    check("fetch_req", 32'(imem_req), 1);
    check("fetch_addr", 32'(imem_addr), 32'(model_pc));
    for (int i = 0; i < delay; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      start      = 1'($urandom);
      step();
      check("wait_req", 32'(imem_req), 1);
      check("wait_addr", 32'(imem_addr), 32'(model_pc));
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    zero_flag  = ~z;
    step();
    imem_ack   = 1'($urandom);
    imem_rdata = $urandom;
    zero_flag  = ~z;
    check("exec_req", 32'(imem_req), 0);
    check("exec_busy", 32'(busy), 1);
    check("exec_we", 32'(write_enable), 0);
    check_fields("exec", w);
    step();
    zero_flag = z;
    start     = 1'b0;
    check("wb_we", 32'(write_enable), (op == 1) ? 1 : 0);
    check("wb_busy", 32'(busy), 1);
    check_fields("wb", w);
    step();
    imem_ack = 1'b0;
    model_retired++;
    case (op)
      2:       model_pc = z ? tgt : (model_pc + 1) % 256;
      3:       model_pc = tgt;
      15:      model_pc = model_pc;
      default: model_pc = (model_pc + 1) % 256;
    endcase
    check("post_we", 32'(write_enable), 0);
`ifdef SEQ_PERF_CNT_EN
    check("instr_count", instr_count, 32'(model_retired));
`endif
    if (op == 15) begin
      check("halt_halted", 32'(halted), 1);
      check("halt_busy", 32'(busy), 0);
      check("halt_req", 32'(imem_req), 0);
    end
  endtask

  task automatic random_instr();
    run_instr(enc($urandom_range(0, 14), $urandom, $urandom, $urandom, $urandom, $urandom),
              $urandom_range(0, 3), 1'($urandom));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0; zero_flag = 1'b0;
    repeat (2) step();
    check("rst_req", 32'(imem_req), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_rd", 32'(write_reg), 0);
    rst = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("pre_reset_req", 32'(imem_req), 1);
    #2 rst = 1'b0;
    #1;
    check("async_req", 32'(imem_req), 0);
    check("async_we", 32'(write_enable), 0);
    check("async_busy", 32'(busy), 0);
    step();
    rst   = 1'b1;
    start = 1'b1;
    step();
    check("release_start_busy", 32'(busy), 0);
    check("release_addr", 32'(imem_addr), 0);
    step();
    start = 1'b0;
    model_pc = 0;
    model_retired = 0;

    run_instr(enc(1, 1, 2, 2, 8'h28, 3), 0, 1'b0);
    run_instr(enc(0, 7, 9, 11, 8'hA5, 6), 3, 1'b1);
    run_instr(enc(2, 3, 4, 5, 8'h40, 1), 0, 1'b1);
    run_instr(enc(2, 3, 4, 5, 8'h40, 1), 2, 1'b0);
    run_instr(enc(3, 1, 1, 1, 8'hFF, 2), 1, 1'b0);
    run_instr(enc(0, 2, 2, 2, 8'h11, 4), 0, 1'b0);
    check("wrap_addr", 32'(imem_addr), 0);

    for (int i = 0; i < 40; i++) random_instr();

    run_instr(enc(15, 5, 6, 7, 8'h33, 9), 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_hold_req", 32'(imem_req), 0);
      check("halt_hold_halted", 32'(halted), 1);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    model_pc = 0;
    check("restart_halted", 32'(halted), 0);
    for (int i = 0; i < 30; i++) random_instr();
    run_instr(enc(15, 0, 0, 0, 0, 0), 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
